// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + producer tag).
// Commits write values in order; renames mark registers busy; lookups answer with value or tag.
module reg_status_file #(
    parameter int REG_NUM      = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic [4:0]              ID_rs1,
    input  logic [4:0]              ID_rs2,
    output logic [DATA_WIDTH-1:0]   ID_rs1_value,
    output logic                    ID_rs1_busy,
    output logic [ROB_ID_WIDTH-1:0] ID_rs1_ROB_id,
    output logic [DATA_WIDTH-1:0]   ID_rs2_value,
    output logic                    ID_rs2_busy,
    output logic [ROB_ID_WIDTH-1:0] ID_rs2_ROB_id,
    input  logic                    ID_rename_valid,
    input  logic [4:0]              ID_rename_rd,
    input  logic [ROB_ID_WIDTH-1:0] ID_rename_ROB_id,
    input  logic                    ROB_commit_valid,
    input  logic [4:0]              ROB_commit_rd,
    input  logic [ROB_ID_WIDTH-1:0] ROB_commit_ROB_id,
    input  logic [DATA_WIDTH-1:0]   ROB_commit_value,
    input  logic                    ROB_flush
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   value;
        logic                    busy;
        logic [ROB_ID_WIDTH-1:0] tag;
    } lookup_t;

    logic [DATA_WIDTH-1:0]   reg_value [REG_NUM];
    logic                    reg_busy  [REG_NUM];
    logic [ROB_ID_WIDTH-1:0] reg_tag   [REG_NUM];

    logic    rename_fire;
    logic    commit_fire;
    logic    commit_clear;
    lookup_t rs1_res;
    lookup_t rs2_res;

    assign rename_fire = ID_rename_valid & ~ROB_flush & (ID_rename_rd != 5'd0);
    assign commit_fire = ROB_commit_valid & (ROB_commit_rd != 5'd0);

    // A commit only releases rd if it is still the newest producer and is not re-renamed this cycle.
    assign commit_clear = commit_fire
                        & (reg_tag[ROB_commit_rd] == ROB_commit_ROB_id)
                        & ~(rename_fire & (ID_rename_rd == ROB_commit_rd));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                reg_value[i] <= '0;
                reg_busy[i]  <= 1'b0;
                reg_tag[i]   <= '0;
            end
        end else if (rdy) begin
            if (commit_fire) begin
                reg_value[ROB_commit_rd] <= ROB_commit_value;
                if (commit_clear)
                    reg_busy[ROB_commit_rd] <= 1'b0;
            end
            if (ROB_flush) begin
                for (int i = 0; i < REG_NUM; i++)
                    reg_busy[i] <= 1'b0;
            end else if (rename_fire) begin
                reg_busy[ID_rename_rd] <= 1'b1;
                reg_tag[ID_rename_rd]  <= ID_rename_ROB_id;
            end
        end
    end

    // Lookups see pre-rename state, with a same-cycle bypass from the matching commit.
    function automatic lookup_t lookup(input logic [4:0] s);
        lookup_t r;
        r.value = reg_value[s];
        r.busy  = reg_busy[s];
        r.tag   = reg_tag[s];
        if (s == 5'd0) begin
            r = '0;
        end else if (reg_busy[s] && ROB_commit_valid && (ROB_commit_rd == s)
                     && (ROB_commit_ROB_id == reg_tag[s])) begin
            r.value = ROB_commit_value;
            r.busy  = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        rs1_res = lookup(ID_rs1);
        rs2_res = lookup(ID_rs2);
    end

    assign ID_rs1_value  = rs1_res.value;
    assign ID_rs1_busy   = rs1_res.busy;
    assign ID_rs1_ROB_id = rs1_res.tag;
    assign ID_rs2_value  = rs2_res.value;
    assign ID_rs2_busy   = rs2_res.busy;
    assign ID_rs2_ROB_id = rs2_res.tag;

endmodule
